// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM sequencing FETCH/DECODE/EXEC/MEM/WB for the datapath
//
// Ports:
//   clk         in   rising-edge system clock
//   reset       in   asynchronous active-low reset
//   instr       in   IR contents (stable from DECODE until the next FETCH)
//   branch      in   ALU equal flag (qualified by the datapath, not used here)
//   mem_ready   in   DM handshake, only looked at in MEM
//   IRWrite     out  load IR from IM
//   PCWrite     out  load PC from NPC (exactly once per instruction)
//   NPCOp       out  0=PC+4 1=branch 2=j/jal 3=jr
//   EXTOp       out  0=zero 1=sign extend
//   ALUControl  out  0=add 1=sub 2=or 3=lui
//   ALUDataSrc  out  0=RD2 1=imm
//   RegAddrSrc  out  0=rt 1=rd 2=$31
//   RegDataSrc  out  0=ALU 1=MemRD 2=PC+4
//   RegWrite    out  GRF write enable
//   MemWrite    out  DM write strobe
//   MemDataSrc  out  constant 0
//   MemDataType out  constant 0
//   mem_req     out  DM access request
//   illegal     out  one-cycle pulse on an undecoded instruction
//   retired     out  retired-instruction counter (wraps)
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             branch,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [2:0]       NPCOp,
    output logic             EXTOp,
    output logic [3:0]       ALUControl,
    output logic             ALUDataSrc,
    output logic [1:0]       RegAddrSrc,
    output logic [1:0]       RegDataSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [2:0]       MemDataSrc,
    output logic [2:0]       MemDataType,
    output logic             mem_req,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_EXEC_J, S_MEM, S_WB
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_rtype;
    logic       w_addu, w_subu, w_jr;
    logic       w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic       w_ill;
    logic       w_jclass;
    logic [3:0] w_alu_ctl;
    logic       w_alu_src;
    logic       w_ext;
    logic       w_alu_on;
    logic       w_unused;

    assign w_op    = instr[31:26];
    assign w_funct = instr[5:0];
    assign w_rtype = w_op == 6'h00;
    assign w_addu  = w_rtype && w_funct == 6'h21;
    assign w_subu  = w_rtype && w_funct == 6'h23;
    assign w_jr    = w_rtype && w_funct == 6'h08;
    assign w_ori   = w_op == 6'h0d;
    assign w_lui   = w_op == 6'h0f;
    assign w_lw    = w_op == 6'h23;
    assign w_sw    = w_op == 6'h2b;
    assign w_beq   = w_op == 6'h04;
    assign w_j     = w_op == 6'h02;
    assign w_jal   = w_op == 6'h03;
    assign w_ill   = !(w_addu || w_subu || w_jr || w_ori || w_lui ||
                       w_lw || w_sw || w_beq || w_j || w_jal);

    // Ops that finish in EXEC_J: control transfers plus illegal, which just steps PC
    assign w_jclass = w_j || w_jal || w_jr || w_beq || w_ill;

    // ALU setup is a pure function of the op so it can be held unchanged
    // from DECODE through WB, keeping ALUResult stable for the write-back
    assign w_alu_ctl = (w_subu || w_beq) ? 4'd1 : w_ori ? 4'd2 : w_lui ? 4'd3 : 4'd0;
    assign w_alu_src = w_ori || w_lui || w_lw || w_sw;
    assign w_ext     = w_lw || w_sw || w_beq;
    assign w_alu_on  = r_state != S_RST && r_state != S_FETCH;

    // branch is consumed by the datapath's NPC; rs/rt/rd/imm fields are not needed here
    assign w_unused = ^{branch, instr[25:6]};

    assign retired = r_retired;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RST;
            r_retired <= '0;
        end else begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, PCWrite};
            case (r_state)
                S_RST:    r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: r_state <= w_jclass ? S_EXEC_J : S_EXEC;
                S_EXEC:   r_state <= (w_lw || w_sw) ? S_MEM : S_WB;
                S_EXEC_J: r_state <= S_FETCH;
                S_MEM:    r_state <= !mem_ready ? S_MEM : w_lw ? S_WB : S_FETCH;
                S_WB:     r_state <= S_FETCH;
                default:  r_state <= S_RST;
            endcase
        end
    end

    // Outputs decode straight from the state register so reset clears them
    // asynchronously; only MEM looks at mem_ready, to strobe sw completion
    always_comb begin
        IRWrite     = r_state == S_FETCH;
        PCWrite     = 1'b0;
        NPCOp       = 3'd0;
        EXTOp       = w_alu_on ? w_ext : 1'b0;
        ALUControl  = w_alu_on ? w_alu_ctl : 4'd0;
        ALUDataSrc  = w_alu_on ? w_alu_src : 1'b0;
        RegAddrSrc  = 2'd0;
        RegDataSrc  = 2'd0;
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        MemDataSrc  = 3'd0;
        MemDataType = 3'd0;
        mem_req     = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_EXEC_J: begin
                PCWrite    = 1'b1;
                NPCOp      = w_beq ? 3'd1 : (w_j || w_jal) ? 3'd2 : w_jr ? 3'd3 : 3'd0;
                RegWrite   = w_jal;
                RegAddrSrc = w_jal ? 2'd2 : 2'd0;
                RegDataSrc = w_jal ? 2'd2 : 2'd0;
                illegal    = w_ill;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                MemWrite = w_sw && mem_ready;
                PCWrite  = w_sw && mem_ready;
            end
            S_WB: begin
                PCWrite    = 1'b1;
                RegWrite   = 1'b1;
                RegAddrSrc = w_rtype ? 2'd1 : 2'd0;
                RegDataSrc = w_lw ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end
endmodule
